// File: rtl/trdb_stream_arbiter.sv
// Packet-source arbiter in front of the shared stream packer; holds a source until its packet
// is granted and slots flushes between packets. Define TRDB_STREAM_ARB_RR_EN for round-robin.
package trdb_pkg;
    localparam int unsigned PACKET_LEN = 32;
endpackage

module trdb_stream_arbiter #(
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned PACKET_LEN = trdb_pkg::PACKET_LEN,
    parameter int unsigned LEN_W      = $clog2(PACKET_LEN)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_SRC*PACKET_LEN-1:0] src_bits_i,
    input  logic [NUM_SRC*LEN_W-1:0]      src_len_i,
    input  logic [NUM_SRC-1:0]            src_valid_i,
    output logic [NUM_SRC-1:0]            src_grant_o,
    output logic [PACKET_LEN-1:0]         align_bits_o,
    output logic [LEN_W-1:0]              align_len_o,
    output logic                          align_valid_o,
    input  logic                          align_grant_i,
    output logic                          align_flush_o,
    input  logic                          align_flush_confirm_i,
    input  logic                          flush_req_i,
    output logic                          flush_done_o,
    output logic                          busy_o,
    output logic [$clog2(NUM_SRC)-1:0]    cur_src_o
);
    localparam int unsigned SelW = $clog2(NUM_SRC);

    typedef enum logic [1:0] {StIdle, StLocked, StFlush} state_e;

    state_e              state_q, state_d;
    logic [SelW-1:0]     sel_q, sel_d;
    logic                flush_pend_q, flush_pend_d;
    logic                flush_done_q, flush_done_d;
    logic [SelW-1:0]     winner;
    logic                any_valid;
    logic [PACKET_LEN-1:0] sel_bits;
    logic [LEN_W-1:0]    sel_len;
    logic                sel_valid;
    logic                pkt_done;

    assign any_valid = |src_valid_i;
    assign pkt_done  = (state_q == StLocked) && sel_valid && align_grant_i;

`ifdef TRDB_STREAM_ARB_RR_EN
    logic [SelW-1:0] rr_q, rr_d;
    logic            hi_found, lo_found;
    logic [SelW-1:0] hi_idx, lo_idx;

    // Indices above the last granted source win first; otherwise wrap to the lowest valid one.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!hi_found && src_valid_i[i] && (SelW'(i) > rr_q)) begin
                hi_found = 1'b1;
                hi_idx   = SelW'(i);
            end
            if (!lo_found && src_valid_i[i]) begin
                lo_found = 1'b1;
                lo_idx   = SelW'(i);
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    assign rr_d = pkt_done ? sel_q : rr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= SelW'(NUM_SRC - 1);
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    logic found;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (!found && src_valid_i[i]) begin
                found  = 1'b1;
                winner = SelW'(i);
            end
        end
    end
`endif

    always_comb begin
        sel_bits  = '0;
        sel_len   = '0;
        sel_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel_q == SelW'(i)) begin
                sel_bits  = src_bits_i[i*PACKET_LEN +: PACKET_LEN];
                sel_len   = src_len_i[i*LEN_W +: LEN_W];
                sel_valid = src_valid_i[i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            sel_q        <= '0;
            flush_pend_q <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            flush_pend_q <= flush_pend_d;
            flush_done_q <= flush_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        flush_pend_d = flush_pend_q | flush_req_i;
        flush_done_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (flush_pend_q) begin
                    state_d = StFlush;
                end else if (any_valid) begin
                    sel_d   = winner;
                    state_d = StLocked;
                end
            end
            // A dropped valid abandons the lock without a grant.
            StLocked: begin
                if (!sel_valid || align_grant_i) begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (align_flush_confirm_i) begin
                    flush_pend_d = flush_req_i;
                    flush_done_d = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        src_grant_o   = '0;
        align_bits_o  = '0;
        align_len_o   = '0;
        align_valid_o = 1'b0;
        align_flush_o = 1'b0;
        unique case (state_q)
            StLocked: begin
                align_bits_o  = sel_bits;
                align_len_o   = sel_len;
                align_valid_o = sel_valid;
                if (pkt_done) begin
                    src_grant_o[sel_q] = 1'b1;
                end
            end
            StFlush: align_flush_o = 1'b1;
            default: ;
        endcase
    end

    assign busy_o       = (state_q != StIdle) || flush_pend_q;
    assign flush_done_o = flush_done_q;
    assign cur_src_o    = sel_q;

endmodule

// File: tb/tb_trdb_stream_arbiter.sv
// Self-checking bench for trdb_stream_arbiter: directed scenarios plus randomized packets
// checked against a transaction-level arbitration model.
module tb_trdb_stream_arbiter;
    localparam int N  = 2;
    localparam int PL = 32;
    localparam int LW = 5;
    localparam int SW = 1;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic [N*PL-1:0] src_bits;
    logic [N*LW-1:0] src_len;
    logic [N-1:0]  src_valid;
    logic [N-1:0]  src_grant;
    logic [PL-1:0] align_bits;
    logic [LW-1:0] align_len;
    logic          align_valid, align_grant, align_flush, align_flush_confirm;
    logic          flush_req, flush_done, busy;
    logic [SW-1:0] cur_src;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    trdb_stream_arbiter #(
        .NUM_SRC    (N),
        .PACKET_LEN (PL)
    ) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_ni),
        .src_bits_i            (src_bits),
        .src_len_i             (src_len),
        .src_valid_i           (src_valid),
        .src_grant_o           (src_grant),
        .align_bits_o          (align_bits),
        .align_len_o           (align_len),
        .align_valid_o         (align_valid),
        .align_grant_i         (align_grant),
        .align_flush_o         (align_flush),
        .align_flush_confirm_i (align_flush_confirm),
        .flush_req_i           (flush_req),
        .flush_done_o          (flush_done),
        .busy_o                (busy),
        .cur_src_o             (cur_src)
    );

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic chk();
        @(negedge clk);
    endtask

    task automatic set_src(input int s, input logic v, input logic [PL-1:0] b,
                           input logic [LW-1:0] l);
        src_valid[s]       = v;
        src_bits[s*PL +: PL] = b;
        src_len[s*LW +: LW]  = l;
    endtask

    task automatic apply_reset();
        rst_ni              = 1'b0;
        src_valid           = '0;
        src_bits            = '0;
        src_len             = '0;
        align_grant         = 1'b0;
        align_flush_confirm = 1'b0;
        flush_req           = 1'b0;
        drv();
        drv();
        rst_ni = 1'b1;
    endtask

    // Reference arbitration rule: which source should win given valids and last granted index.
    function automatic int model_pick(input logic [N-1:0] v, input int last);
`ifdef TRDB_STREAM_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
`else
        for (int c = 0; c < N; c++) begin
            if (v[c]) return c;
        end
`endif
        return -1;
    endfunction

    task automatic test_reset();
        rst_ni = 1'b0;
        chk();
        n_checks++;
        if ({src_grant, align_valid, align_flush, flush_done, busy, cur_src} !== '0)
            $display("FAIL reset_ctrl: got %b want 0",
                     {src_grant, align_valid, align_flush, flush_done, busy, cur_src});
        else n_pass++;
        n_checks++;
        if ({align_bits, align_len} !== '0)
            $display("FAIL reset_data: got %h want 0", {align_bits, align_len});
        else n_pass++;
    endtask

    task automatic test_single();
        apply_reset();
        set_src(0, 1'b1, 32'h000A_BCDE, 5'd20);
        drv(); chk();
        n_checks++;
        if (align_valid !== 1'b1 || align_bits !== 32'h000A_BCDE || align_len !== 5'd20)
            $display("FAIL single_issue: got v=%b bits=%h len=%0d want v=1 bits=abcde len=20",
                     align_valid, align_bits, align_len);
        else n_pass++;
        drv(); chk();
        n_checks++;
        if (align_valid !== 1'b1 || src_grant !== 2'b00)
            $display("FAIL single_hold: got v=%b grant=%b want v=1 grant=00",
                     align_valid, src_grant);
        else n_pass++;
        drv(); align_grant = 1'b1; chk();
        n_checks++;
        if (src_grant !== 2'b01) $display("FAIL single_grant: got %b want 01", src_grant);
        else n_pass++;
        drv(); align_grant = 1'b0; set_src(0, 1'b0, '0, '0); chk();
        n_checks++;
        if (busy !== 1'b0 || align_valid !== 1'b0 || src_grant !== 2'b00)
            $display("FAIL single_idle: got busy=%b v=%b grant=%b want 0 0 00",
                     busy, align_valid, src_grant);
        else n_pass++;
    endtask

    task automatic test_arbitration();
        int got[$];
        int exp_order[4];
`ifdef TRDB_STREAM_ARB_RR_EN
        exp_order = '{0, 1, 0, 1};
`else
        exp_order = '{0, 0, 0, 0};
`endif
        apply_reset();
        set_src(0, 1'b1, 32'h1111_0000, 5'd7);
        set_src(1, 1'b1, 32'h2222_0000, 5'd9);
        align_grant = 1'b1;
        for (int c = 0; c < 20 && got.size() < 4; c++) begin
            drv(); chk();
            if (src_grant !== 2'b00) got.push_back(src_grant == 2'b10 ? 1 : 0);
        end
        n_checks++;
        if (got.size() != 4) $display("FAIL arb_count: got %0d grants want 4", got.size());
        else n_pass++;
        for (int i = 0; i < got.size(); i++) begin
            n_checks++;
            if (got[i] != exp_order[i])
                $display("FAIL arb_order[%0d]: got src%0d want src%0d", i, got[i], exp_order[i]);
            else n_pass++;
        end
        drv(); align_grant = 1'b0; src_valid = '0;
        drv();
    endtask

    task automatic test_deferred_flush();
        apply_reset();
        set_src(1, 1'b1, 32'hCAFE_0001, 5'd12);
        drv(); set_src(0, 1'b1, 32'h0000_BEEF, 5'd16); flush_req = 1'b1; chk();
        n_checks++;
        if (cur_src !== 1'b1 || align_valid !== 1'b1 || align_flush !== 1'b0)
            $display("FAIL dflush_lock: got src=%0d v=%b fl=%b want 1 1 0",
                     cur_src, align_valid, align_flush);
        else n_pass++;
        drv(); flush_req = 1'b0; chk();
        n_checks++;
        if (busy !== 1'b1 || align_flush !== 1'b0)
            $display("FAIL dflush_defer: got busy=%b fl=%b want 1 0", busy, align_flush);
        else n_pass++;
        drv(); align_grant = 1'b1; chk();
        n_checks++;
        if (src_grant !== 2'b10) $display("FAIL dflush_grant: got %b want 10", src_grant);
        else n_pass++;
        drv(); align_grant = 1'b0; set_src(1, 1'b0, '0, '0); chk();
        n_checks++;
        if (align_valid !== 1'b0 || align_flush !== 1'b0 || busy !== 1'b1)
            $display("FAIL dflush_gap: got v=%b fl=%b busy=%b want 0 0 1",
                     align_valid, align_flush, busy);
        else n_pass++;
        for (int c = 0; c < 3; c++) begin
            drv();
            if (c == 2) align_flush_confirm = 1'b1;
            chk();
            n_checks++;
            if (align_flush !== 1'b1 || align_valid !== 1'b0 || flush_done !== 1'b0 ||
                src_grant !== 2'b00)
                $display("FAIL dflush_flush[%0d]: got fl=%b v=%b done=%b grant=%b want 1 0 0 00",
                         c, align_flush, align_valid, flush_done, src_grant);
            else n_pass++;
        end
        drv(); align_flush_confirm = 1'b0; chk();
        n_checks++;
        if (flush_done !== 1'b1 || align_flush !== 1'b0 || align_valid !== 1'b0)
            $display("FAIL dflush_done: got done=%b fl=%b v=%b want 1 0 0",
                     flush_done, align_flush, align_valid);
        else n_pass++;
        drv(); chk();
        n_checks++;
        if (flush_done !== 1'b0 || align_valid !== 1'b1 || cur_src !== 1'b0)
            $display("FAIL dflush_after: got done=%b v=%b src=%0d want 0 1 0",
                     flush_done, align_valid, cur_src);
        else n_pass++;
        drv(); align_grant = 1'b1; chk();
        n_checks++;
        if (src_grant !== 2'b01) $display("FAIL dflush_src0: got %b want 01", src_grant);
        else n_pass++;
        drv(); align_grant = 1'b0; src_valid = '0;
    endtask

    task automatic test_flush_priority();
        apply_reset();
        flush_req = 1'b1;
        drv(); flush_req = 1'b0; set_src(0, 1'b1, 32'h0000_1234, 5'd13); chk();
        n_checks++;
        if (busy !== 1'b1 || align_valid !== 1'b0)
            $display("FAIL prio_pend: got busy=%b v=%b want 1 0", busy, align_valid);
        else n_pass++;
        // Request coincides with the confirm: a second flush must follow.
        drv(); flush_req = 1'b1; align_flush_confirm = 1'b1; chk();
        n_checks++;
        if (align_flush !== 1'b1 || align_valid !== 1'b0)
            $display("FAIL prio_flush1: got fl=%b v=%b want 1 0", align_flush, align_valid);
        else n_pass++;
        drv(); flush_req = 1'b0; align_flush_confirm = 1'b0; chk();
        n_checks++;
        if (flush_done !== 1'b1 || align_valid !== 1'b0 || busy !== 1'b1)
            $display("FAIL prio_done1: got done=%b v=%b busy=%b want 1 0 1",
                     flush_done, align_valid, busy);
        else n_pass++;
        drv(); align_flush_confirm = 1'b1; chk();
        n_checks++;
        if (align_flush !== 1'b1 || align_valid !== 1'b0)
            $display("FAIL prio_flush2: got fl=%b v=%b want 1 0", align_flush, align_valid);
        else n_pass++;
        drv(); align_flush_confirm = 1'b0; chk();
        n_checks++;
        if (flush_done !== 1'b1 || align_valid !== 1'b0)
            $display("FAIL prio_done2: got done=%b v=%b want 1 0", flush_done, align_valid);
        else n_pass++;
        drv(); chk();
        n_checks++;
        if (align_valid !== 1'b1 || cur_src !== 1'b0 || align_bits !== 32'h0000_1234 ||
            busy !== 1'b1)
            $display("FAIL prio_issue: got v=%b src=%0d bits=%h busy=%b want 1 0 1234 1",
                     align_valid, cur_src, align_bits, busy);
        else n_pass++;
        drv(); align_grant = 1'b1; chk();
        drv(); align_grant = 1'b0; src_valid = '0;
    endtask

    task automatic test_valid_drop();
        apply_reset();
        set_src(0, 1'b1, 32'h0F0F_0F0F, 5'd8);
        drv(); chk();
        n_checks++;
        if (align_valid !== 1'b1 || cur_src !== 1'b0)
            $display("FAIL drop_lock: got v=%b src=%0d want 1 0", align_valid, cur_src);
        else n_pass++;
        drv(); set_src(0, 1'b0, 32'h0F0F_0F0F, 5'd8); align_grant = 1'b1; chk();
        n_checks++;
        if (src_grant !== 2'b00 || align_valid !== 1'b0)
            $display("FAIL drop_nogrant: got grant=%b v=%b want 00 0", src_grant, align_valid);
        else n_pass++;
        drv(); align_grant = 1'b0;
        set_src(0, 1'b1, 32'h0F0F_0F0F, 5'd8);
        set_src(1, 1'b1, 32'h7777_7777, 5'd3);
        chk();
        n_checks++;
        if (busy !== 1'b0 || src_grant !== 2'b00)
            $display("FAIL drop_idle: got busy=%b grant=%b want 0 00", busy, src_grant);
        else n_pass++;
        drv(); chk();
        n_checks++;
        if (cur_src !== 1'b0 || align_valid !== 1'b1)
            $display("FAIL drop_ptr: got src=%0d v=%b want 0 1", cur_src, align_valid);
        else n_pass++;
        drv(); align_grant = 1'b1; chk();
        n_checks++;
        if (src_grant !== 2'b01) $display("FAIL drop_regrant: got %b want 01", src_grant);
        else n_pass++;
        drv(); align_grant = 1'b0; src_valid = '0;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        set_src(1, 1'b1, 32'h5A5A_5A5A, 5'd31);
        drv(); flush_req = 1'b1; chk();
        n_checks++;
        if (cur_src !== 1'b1 || align_valid !== 1'b1)
            $display("FAIL mrst_lock: got src=%0d v=%b want 1 1", cur_src, align_valid);
        else n_pass++;
        drv(); flush_req = 1'b0; chk();
        #1 rst_ni = 1'b0;
        #1;
        n_checks++;
        if ({src_grant, align_valid, align_flush, flush_done, busy, cur_src} !== '0 ||
            {align_bits, align_len} !== '0)
            $display("FAIL mrst_async: got ctrl=%b data=%h want 0",
                     {src_grant, align_valid, align_flush, flush_done, busy, cur_src},
                     {align_bits, align_len});
        else n_pass++;
        drv(); set_src(0, 1'b1, 32'h0000_00C3, 5'd4);
        drv(); rst_ni = 1'b1;
        drv(); chk();
        n_checks++;
        if (cur_src !== 1'b0 || align_valid !== 1'b1 || align_flush !== 1'b0)
            $display("FAIL mrst_after: got src=%0d v=%b fl=%b want 0 1 0",
                     cur_src, align_valid, align_flush);
        else n_pass++;
        drv(); align_grant = 1'b1; chk();
        drv(); align_grant = 1'b0; src_valid = '0;
    endtask

    task automatic test_random();
        int            last;
        int            w;
        int            lat;
        logic [N-1:0]  v;
        logic [N-1:0]  eg;
        logic [PL-1:0] b[N];
        logic [LW-1:0] l[N];
        apply_reset();
        last = N - 1;
        for (int p = 0; p < 40; p++) begin
            v = N'($urandom_range(1, (1 << N) - 1));
            for (int s = 0; s < N; s++) begin
                b[s] = $urandom;
                l[s] = LW'($urandom);
                set_src(s, v[s], b[s], l[s]);
            end
            w   = model_pick(v, last);
            lat = 0;
            do begin
                drv(); chk();
                lat++;
            end while (!align_valid && lat < 8);
            n_checks++;
            if (lat != 1 || cur_src !== SW'(w) || align_bits !== b[w] || align_len !== l[w])
                $display("FAIL rand_issue[%0d]: got lat=%0d src=%0d bits=%h len=%0d want 1 %0d %h %0d",
                         p, lat, cur_src, align_bits, align_len, w, b[w], l[w]);
            else n_pass++;
            repeat ($urandom_range(0, 3)) begin
                drv(); chk();
            end
            drv(); align_grant = 1'b1; chk();
            eg    = '0;
            eg[w] = 1'b1;
            n_checks++;
            if (src_grant !== eg)
                $display("FAIL rand_grant[%0d]: got %b want %b", p, src_grant, eg);
            else n_pass++;
            last = w;
            drv(); align_grant = 1'b0;
        end
        src_valid = '0;
        drv();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_ni              = 1'b0;
        src_valid           = '0;
        src_bits            = '0;
        src_len             = '0;
        align_grant         = 1'b0;
        align_flush_confirm = 1'b0;
        flush_req           = 1'b0;
        test_reset();
        test_single();
        test_arbitration();
        test_deferred_flush();
        test_flush_priority();
        test_valid_drop();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
